demux_7_32b_reg: RTL
====================

Name: demux_7_32b_reg

Overview:
- Registered 1-to-7 distributor for 32-bit words. It is the write-side counterpart of the 7-input result mux in the datapath.
- One producer presents a word plus a 3-bit `seletor`. The block steers the word into one of seven single-entry holding registers.
- Each holding register is drained independently by its consumer through a valid/ack handshake.
- `seletor`=7 is the null destination: the word is accepted and discarded, and the discard is counted.

Parameters:
- DATA_W, 32, width of data word and of every holding register
- CNT_W, 8, width of saturating discard counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- flush  input  1  synchronous clear of all channel valids
- seletor  input  3  destination select; 0..6 = channel, 7 = discard
- in_data  input  DATA_W  word to distribute
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts word this cycle (combinational)
- out_0 .. out_6  output  DATA_W each  holding register contents, one port per channel
- out_valid  output  7  bit i = out_i holds an unconsumed word
- out_ack  input  7  bit i = consumer i takes out_i this cycle
- drop_count  output  CNT_W  number of words accepted with seletor=7, saturating

Behaviour:
- Reset (reset=0, asynchronous):
  - out_valid=0, out_0..out_6=0, drop_count=0.
  - Holds while reset=0. Any in-flight word or pending ack is lost.
  - First possible transfer is at the first rising edge after reset returns to 1.
- Effective ack: ack_eff[i] = out_valid[i] & out_ack[i]. An ack on an empty channel is ignored and has no side effect.
- in_ready (combinational):
  - flush=1: in_ready=0.
  - Else seletor=7: in_ready=1.
  - Else in_ready = ~out_valid[seletor] | ack_eff[seletor].
- Transfer: occurs when in_valid & in_ready, sampled at the rising edge.
- Transfer to channel s (0..6): at the edge, out_s <= in_data and out_valid[s] <= 1. Latency is 1 cycle; the word is visible the cycle after acceptance.
- Simultaneous ack and write on the same channel: ack consumes the old word; the new word is latched; out_valid[s] stays 1 with no bubble. Full throughput is 1 word/cycle per channel.
- Ack without write on channel i: out_valid[i] <= 0. out_i retains its last value; it is not cleared.
- Acks on channels other than the write target proceed in the same cycle; all seven channels are independent.
- Transfer with seletor=7: no channel register changes. drop_count <= drop_count+1, saturating at 2^CNT_W-1 (255); it never wraps.
- flush=1 (synchronous):
  - out_valid <= 0 at the edge. Data registers and drop_count are unchanged.
  - in_ready=0, so no write or discard occurs that cycle. Acks that cycle are irrelevant.
- seletor and in_data are don't-care while in_valid=0.
- The producer must hold in_data/seletor stable until transfer.
- No combinational path from in_valid to in_ready. The only path to in_ready is from out_ack, flush and seletor.

Test Plan:
- Reset: drive reset=0 mid-operation with out_valid=7'h15 and drop_count=9 → immediately out_valid=0, all out_i=0, drop_count=0. After release, the first write lands one edge later.
- Basic write: seletor=3, in_data=32'hDEADBEEF, in_valid=1 for one cycle → in_ready=1; next cycle out_3=32'hDEADBEEF and out_valid=7'b0001000. All other out_i stay 0.
- Backpressure:
  - Channel 3 full, out_ack=0, seletor=3, in_valid=1 → in_ready=0 for 5 cycles and out_3 is unchanged.
  - Raise out_ack[3] → in_ready=1 the same cycle. Next cycle out_3 = new word and out_valid[3] stays 1.
- Parallel drain: fill channels 0 and 6, then ack both while writing 32'h1234 to channel 2 → next cycle out_valid=7'b0000100.
- Discard counter: 260 consecutive transfers with seletor=7 → in_ready constantly 1; drop_count reads 255 after 255 transfers and stays 255. No out_i changes.
- Flush: channels 1 and 5 valid; assert flush with in_valid=1, seletor=4 → in_ready=0. Next cycle out_valid=0, out_1/out_5 retain their data, and channel 4 is not written.

Source files
------------

// File: rtl/demux_7_32b_reg.sv
// Registered 1-to-7 word distributor with per-channel valid/ack drain.
// Select 7 discards the word and bumps a saturating drop counter.
module demux_7_32b_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [2:0]        seletor,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_0,
  output logic [DATA_W-1:0] out_1,
  output logic [DATA_W-1:0] out_2,
  output logic [DATA_W-1:0] out_3,
  output logic [DATA_W-1:0] out_4,
  output logic [DATA_W-1:0] out_5,
  output logic [DATA_W-1:0] out_6,
  output logic [6:0]        out_valid,
  input  logic [6:0]        out_ack,
  output logic [CNT_W-1:0]  drop_count
);

  logic [DATA_W-1:0] data_q [7];
  logic [6:0]        vld_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [6:0]        ack_eff;
  logic [7:0]        room;
  logic [7:0]        dec;
  logic              xfer;
  logic [6:0]        wr;
  logic              drop;

  assign ack_eff = vld_q & out_ack;

  // Slot 7 is the discard sink and always has room.
  assign room     = {1'b1, ~vld_q | ack_eff};
  assign in_ready = ~flush & room[seletor];

  assign xfer = in_valid & in_ready;
  assign dec  = 8'(1) << seletor;
  assign wr   = dec[6:0] & {7{xfer}};
  assign drop = dec[7] & xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      vld_q <= (vld_q & ~ack_eff) | wr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 7; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (wr[i]) data_q[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (drop && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_0      = data_q[0];
  assign out_1      = data_q[1];
  assign out_2      = data_q[2];
  assign out_3      = data_q[3];
  assign out_4      = data_q[4];
  assign out_5      = data_q[5];
  assign out_6      = data_q[6];
  assign out_valid  = vld_q;
  assign drop_count = cnt_q;

endmodule
